// File: rtl/ti_reg_ctrl.sv
// ti_reg_ctrl: register-write controller for the SN76489-compatible PSG core.
// Accepts host bytes in latch/data format, holds the tone, noise and
// attenuation registers, and emulates the chip's write-busy window.
// Optional feature: define TI_WR_BUF_EN to place a BUF_DEPTH-entry write FIFO
// in front of the decoder (wr_ready then reflects FIFO fullness only).
`timescale 1ns/1ps
module ti_reg_ctrl #(
  parameter int unsigned BUSY_CYCLES = 32,
  parameter int unsigned BUF_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       busy,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [2:0] noise_ctrl,
  output logic       noise_rst
);

  localparam logic       S_IDLE   = 1'b0;
  localparam logic       S_BUSY   = 1'b1;
  localparam logic [7:0] CNT_LOAD = 8'(BUSY_CYCLES - 1);

  if (BUSY_CYCLES < 1 || BUSY_CYCLES > 255) begin : g_bad_busy
    $error("BUSY_CYCLES must be in 1..255");
  end
  if (BUF_DEPTH < 2 || BUF_DEPTH > 16 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("BUF_DEPTH must be a power of 2 in 2..16");
  end

  logic             state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0][3:0]  vol_q, vol_d;
  logic [2:0][9:0]  tone_q, tone_d;
  logic [2:0]       noise_q, noise_d;
  logic             noise_rst_q, noise_rst_d;
  logic [1:0]       lch_q, lch_d;
  logic             ltype_q, ltype_d;

  logic             apply;
  logic [7:0]       byte_w;
  logic [1:0]       tgt_ch;
  logic             tgt_vol;

`ifdef TI_WR_BUF_EN
  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [7:0]  buf_q [BUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0] count_q;
  logic        empty, full, push, pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PW+1)'(BUF_DEPTH));
  assign push     = wr_valid && !full;
  assign pop      = (state_q == S_IDLE) && !empty;
  assign wr_ready = !full;
  assign busy     = (state_q == S_BUSY) || !empty;
  assign apply    = pop;
  assign byte_w   = buf_q[rd_ptr_q];

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // FIFO storage, no reset needed since occupancy gates every read
  always_ff @(posedge CLK) begin
    if (push) buf_q[wr_ptr_q] <= wr_data;
  end
`else
  assign wr_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_BUSY);
  assign apply    = wr_valid && wr_ready;
  assign byte_w   = wr_data;
`endif

  // Decode the applied byte into register updates and the busy-window FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vol_d       = vol_q;
    tone_d      = tone_q;
    noise_d     = noise_q;
    noise_rst_d = 1'b0;
    lch_d       = lch_q;
    ltype_d     = ltype_q;
    // A latch byte targets its own channel/type; a data byte reuses the latch
    tgt_ch      = byte_w[7] ? byte_w[6:5] : lch_q;
    tgt_vol     = byte_w[7] ? byte_w[4]   : ltype_q;

    if (apply) begin
      if (byte_w[7]) begin
        lch_d   = byte_w[6:5];
        ltype_d = byte_w[4];
      end
      if (tgt_vol) begin
        vol_d[tgt_ch] = byte_w[3:0];
      end else if (tgt_ch == 2'd3) begin
        noise_d     = byte_w[2:0];
        noise_rst_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (tgt_ch == 2'(i)) begin
            if (byte_w[7]) tone_d[i][3:0] = byte_w[3:0];
            else           tone_d[i][9:4] = byte_w[5:0];
          end
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (apply) begin
          state_d = S_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      default: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vol_q       <= '1;
      tone_q      <= '0;
      noise_q     <= '0;
      noise_rst_q <= 1'b0;
      lch_q       <= '0;
      ltype_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vol_q       <= vol_d;
      tone_q      <= tone_d;
      noise_q     <= noise_d;
      noise_rst_q <= noise_rst_d;
      lch_q       <= lch_d;
      ltype_q     <= ltype_d;
    end
  end

  assign vol0       = vol_q[0];
  assign vol1       = vol_q[1];
  assign vol2       = vol_q[2];
  assign vol3       = vol_q[3];
  assign tone0      = tone_q[0];
  assign tone1      = tone_q[1];
  assign tone2      = tone_q[2];
  assign noise_ctrl = noise_q;
  assign noise_rst  = noise_rst_q;

endmodule

// File: tb/tb_ti_reg_ctrl.sv
// Bench for ti_reg_ctrl: directed scenarios plus random writes checked
// against a register-level model of the SN76489 latch/data protocol.
`timescale 1ns/1ps
module tb_ti_reg_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready, busy, noise_rst;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [9:0] tone0, tone1, tone2;
  logic [2:0] noise_ctrl;
  logic [48:0] obs;

  int vectors = 0;
  int miscompares = 0;

  ti_reg_ctrl #(.BUSY_CYCLES(32), .BUF_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
    .tone0(tone0), .tone1(tone1), .tone2(tone2),
    .noise_ctrl(noise_ctrl), .noise_rst(noise_rst)
  );

  always #5 CLK = ~CLK;

  assign obs = {vol3, vol2, vol1, vol0, tone2, tone1, tone0, noise_ctrl};

  // Reference model: chip registers plus the latched target
  logic [3:0] m_vol [4];
  logic [9:0] m_tone [3];
  logic [2:0] m_noise;
  int         m_ch;
  bit         m_type;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_vol[i] = 4'hF;
    for (int i = 0; i < 3; i++) m_tone[i] = '0;
    m_noise = '0;
    m_ch = 0;
    m_type = 1'b0;
  endfunction

  // Returns 1 when the byte writes the noise register
  function automatic bit model_apply(input logic [7:0] b);
    if (b[7]) begin
      m_ch   = int'(b[6:5]);
      m_type = b[4];
    end
    if (m_type) begin
      m_vol[m_ch] = b[3:0];
      return 1'b0;
    end
    if (m_ch == 3) begin
      m_noise = b[2:0];
      return 1'b1;
    end
    if (b[7]) m_tone[m_ch] = {m_tone[m_ch][9:4], b[3:0]};
    else      m_tone[m_ch] = {b[5:0], m_tone[m_ch][3:0]};
    return 1'b0;
  endfunction

  function automatic logic [48:0] model_vec();
    return {m_vol[3], m_vol[2], m_vol[1], m_vol[0],
            m_tone[2], m_tone[1], m_tone[0], m_noise};
  endfunction

  // Holds the byte on the port until it transfers; waits = cycles stalled
  task automatic write_byte(input logic [7:0] b, output int waits, output bit np);
    bit r, done;
    done = 1'b0;
    waits = 0;
    np = 1'b0;
    wr_valid = 1'b1;
    wr_data = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      r = wr_ready;
      @(posedge CLK);
      if (r) begin
        done = 1'b1;
        break;
      end
      waits++;
    end
    #1;
    wr_valid = 1'b0;
    wr_data = 8'($urandom);
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL write_timeout byte %h never accepted (wr_ready stayed 0)", b);
    end else begin
      np = model_apply(b);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (wr_ready && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL idle_timeout wr_ready=%b busy=%b required 1/0", wr_ready, busy);
    end
  endtask

  task automatic test_reset();
    @(posedge CLK); #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    @(negedge CLK);
    vectors += 4;
    if (obs !== model_vec()) begin miscompares++; $display("FAIL reset_regs got %h exp %h", obs, model_vec()); end
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", wr_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (noise_rst !== 1'b0) begin miscompares++; $display("FAIL reset_nrst got %b exp 0", noise_rst); end
  endtask

`ifndef TI_WR_BUF_EN
  task automatic test_tone();
    int w, cnt;
    bit np;
    logic [7:0] seq [2];
    seq[0] = 8'hA5;
    seq[1] = 8'h3F;
    for (int k = 0; k < 2; k++) begin
      write_byte(seq[k], w, np);
      @(negedge CLK);
      vectors += 2;
      if (obs !== model_vec()) begin miscompares++; $display("FAIL tone_regs[%0d] got %h exp %h", k, obs, model_vec()); end
      if (busy !== 1'b1) begin miscompares++; $display("FAIL tone_busy[%0d] got %b exp 1", k, busy); end
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
        @(negedge CLK);
        if (wr_ready) break;
        cnt++;
      end
      vectors++;
      if (cnt != 32) begin miscompares++; $display("FAIL tone_window[%0d] got %0d exp 32", k, cnt); end
    end
    vectors++;
    if (tone1 !== 10'h3F5) begin miscompares++; $display("FAIL tone1_value got %h exp 3f5", tone1); end
  endtask

  task automatic test_volume();
    int w;
    bit np;
    write_byte(8'h90, w, np);
    @(negedge CLK);
    vectors++;
    if (vol0 !== 4'h0) begin miscompares++; $display("FAIL vol0_latch got %h exp 0", vol0); end
    wait_idle();
    write_byte(8'h07, w, np);
    @(negedge CLK);
    vectors += 2;
    if (vol0 !== 4'h7) begin miscompares++; $display("FAIL vol0_data got %h exp 7", vol0); end
    if (obs !== model_vec()) begin miscompares++; $display("FAIL vol_regs got %h exp %h", obs, model_vec()); end
    wait_idle();
  endtask

  task automatic test_noise();
    int w;
    bit np;
    logic [7:0] seq [3];
    logic [2:0] nexp [3];
    seq[0] = 8'hE4; nexp[0] = 3'b100;
    seq[1] = 8'h03; nexp[1] = 3'b011;
    seq[2] = 8'h03; nexp[2] = 3'b011;
    for (int k = 0; k < 3; k++) begin
      write_byte(seq[k], w, np);
      @(negedge CLK);
      vectors += 3;
      if (noise_ctrl !== nexp[k]) begin miscompares++; $display("FAIL noise_val[%0d] got %b exp %b", k, noise_ctrl, nexp[k]); end
      if (noise_rst !== 1'b1) begin miscompares++; $display("FAIL noise_pulse[%0d] got %b exp 1", k, noise_rst); end
      if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL noise_ready[%0d] got %b exp 0", k, wr_ready); end
      @(negedge CLK);
      vectors++;
      if (noise_rst !== 1'b0) begin miscompares++; $display("FAIL noise_pulse_end[%0d] got %b exp 0", k, noise_rst); end
      wait_idle();
    end
  endtask

  task automatic test_reset_midbusy();
    int w;
    bit np;
    write_byte(8'h8A, w, np);
    wr_valid = 1'b1;
    wr_data = 8'h15;
    repeat (10) @(negedge CLK);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    wr_valid = 1'b0;
    model_reset();
    @(negedge CLK);
    vectors += 3;
    if (obs !== model_vec()) begin miscompares++; $display("FAIL midreset_regs got %h exp %h", obs, model_vec()); end
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready got %b exp 1", wr_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy got %b exp 0", busy); end
    repeat (3) @(negedge CLK);
    vectors++;
    if (obs !== model_vec()) begin miscompares++; $display("FAIL midreset_held got %h exp %h", obs, model_vec()); end
  endtask

  task automatic test_random();
    int w;
    bit np;
    logic [7:0] b;
    for (int i = 0; i < 60; i++) begin
      b = 8'($urandom);
      write_byte(b, w, np);
      if (i > 0) begin
        vectors++;
        if (w != 31) begin miscompares++; $display("FAIL rnd_stall[%0d] got %0d exp 31", i, w); end
      end
      @(negedge CLK);
      vectors += 3;
      if (obs !== model_vec()) begin miscompares++; $display("FAIL rnd_regs[%0d] byte %h got %h exp %h", i, b, obs, model_vec()); end
      if (noise_rst !== np) begin miscompares++; $display("FAIL rnd_nrst[%0d] byte %h got %b exp %b", i, b, noise_rst, np); end
      if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL rnd_ready[%0d] got %b exp 0", i, wr_ready); end
    end
    wait_idle();
  endtask
`else
  task automatic test_buffer();
    int w;
    bit np;
    logic [7:0] seq [6];
    seq[0] = 8'h81; seq[1] = 8'h05; seq[2] = 8'h82;
    seq[3] = 8'h0A; seq[4] = 8'h83; seq[5] = 8'h11;
    for (int k = 0; k < 6; k++) begin
      write_byte(seq[k], w, np);
      vectors++;
      if (k < 4 && w != 0) begin miscompares++; $display("FAIL buf_accept[%0d] got %0d stalls exp 0", k, w); end
      else if (k == 5 && w == 0) begin miscompares++; $display("FAIL buf_full got %0d stalls exp >0", w); end
    end
    @(negedge CLK);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL buf_busy got %b exp 1", busy); end
    wait_idle();
    vectors += 2;
    if (obs !== model_vec()) begin miscompares++; $display("FAIL buf_regs got %h exp %h", obs, model_vec()); end
    if (tone0 !== 10'h113) begin miscompares++; $display("FAIL buf_order got %h exp 113", tone0); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef TI_WR_BUF_EN
    test_buffer();
`else
    test_tone();
    test_volume();
    test_noise();
    test_reset_midbusy();
    test_random();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
